// File: rtl/debounce_pkg.sv
// Shared constants, channel state encoding and width helper for the debouncer family.
package debounce_pkg;

  localparam int DEF_TICK_DIV     = 50000;
  localparam int DEF_STABLE_TICKS = 16;

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_SETTLING = 1'b1
  } chan_state_t;

  // Counter width for values 0..n-1; a 1-bit counter is kept even when n is 1.
  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clocks, shared by slow samplers.
module tick_gen
  import debounce_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int            TW   = clog2_min1(TICK_DIV);
  localparam logic [TW-1:0] LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] tcnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)              tcnt <= '0;
    else if (tcnt == LAST)  tcnt <= '0;
    else                    tcnt <= tcnt + TW'(1);
  end

  // With TICK_DIV=1, LAST is 0 and tcnt never leaves it, so tick stays high.
  assign tick = (tcnt == LAST);

endmodule

// File: rtl/button_debouncer.sv
// Multi-channel switch debouncer: 2-flop synchronizer, shared sample tick, per-channel window counter.
//   state       | meaning
//   ST_STABLE   | synchronized input equals dataOut, counter held at 0
//   ST_SETTLING | synchronized input differs, counting ticks toward STABLE_TICKS
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] rawIn,
  output logic [WIDTH-1:0] dataOut,
  output logic [WIDTH-1:0] settling
);

  localparam int            CW       = clog2_min1(STABLE_TICKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic             tick;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= rawIn;
      s2 <= s1;
    end
  end

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clock(clock),
    .reset(reset),
    .tick (tick)
  );

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    logic [CW-1:0] cnt;
    logic          dout;
    chan_state_t   state;

    // State is the mismatch itself, so a returning input leaves SETTLING the same cycle.
    assign state = (s2[i] != dout) ? ST_SETTLING : ST_STABLE;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        cnt  <= '0;
        dout <= 1'b0;
      end else begin
        case (state)
          ST_STABLE: cnt <= '0;
          ST_SETTLING: begin
            if (tick) begin
              if (cnt == CNT_LAST) begin
                dout <= s2[i];
                cnt  <= '0;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
          end
        endcase
      end
    end

    assign dataOut[i]  = dout;
    assign settling[i] = (state == ST_SETTLING);
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: directed vector tables, bounce/reset/tick sequences, random vs model.
module tb_button_debouncer;

  localparam int TD_A = 1, ST_A = 4;
  localparam int TD_B = 3, ST_B = 2;
  localparam int TD_C = 5, ST_C = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] raw_a = '0, raw_b = '0, raw_c = '0;
  logic [3:0] dout_a, sett_a, dout_b, sett_b, dout_c, sett_c;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  button_debouncer #(.WIDTH(4), .TICK_DIV(TD_A), .STABLE_TICKS(ST_A)) dut_a (
    .clock(clock), .reset(reset), .rawIn(raw_a), .dataOut(dout_a), .settling(sett_a));
  button_debouncer #(.WIDTH(4), .TICK_DIV(TD_B), .STABLE_TICKS(ST_B)) dut_b (
    .clock(clock), .reset(reset), .rawIn(raw_b), .dataOut(dout_b), .settling(sett_b));
  button_debouncer #(.WIDTH(4), .TICK_DIV(TD_C), .STABLE_TICKS(ST_C)) dut_c (
    .clock(clock), .reset(reset), .rawIn(raw_c), .dataOut(dout_c), .settling(sett_c));

  typedef struct {
    logic [3:0] raw;
    logic [3:0] dout;
    logic [3:0] sett;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic [3:0] r, input logic [3:0] d, input logic [3:0] s,
                              input int n);
    for (int k = 0; k < n; k++) vq.push_back('{raw: r, dout: d, sett: s});
  endfunction

  // Each vector: rawIn driven before the edge, outputs sampled 1 time unit after it.
  task automatic apply_a(input string tag);
    for (int k = 0; k < vq.size(); k++) begin
      raw_a = vq[k].raw;
      @(posedge clock);
      #1;
      check($sformatf("%s_dout_e%0d", tag, k), 32'(dout_a), 32'(vq[k].dout));
      check($sformatf("%s_sett_e%0d", tag, k), 32'(sett_a), 32'(vq[k].sett));
      @(negedge clock);
    end
    vq.delete();
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Reference model for dut_c: an output adopts the synchronized input once the input has
  // disagreed with it through STABLE_TICKS sample ticks without ever coming back.
  logic [3:0] m_s1, m_s2, m_dout;
  int         tph;
  int         win_ticks[4];

  task automatic model_step();
    bit tk;
    tk = (tph == TD_C - 1);
    for (int i = 0; i < 4; i++) begin
      if (m_s2[i] != m_dout[i]) begin
        if (tk) win_ticks[i]++;
        if (win_ticks[i] == ST_C) begin
          m_dout[i]    = m_s2[i];
          win_ticks[i] = 0;
        end
      end else begin
        win_ticks[i] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = raw_c;
    tph  = (tph + 1) % TD_C;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tick_hits;
    int rise_edge, trans, settle_edge, exp_rise;
    logic prev;

    // Reset state
    @(negedge clock);
    @(negedge clock);
    check("rst_dout_a", 32'(dout_a), 0);
    check("rst_sett_a", 32'(sett_a), 0);
    check("rst_dout_b", 32'(dout_b), 0);
    check("rst_dout_c", 32'(dout_c), 0);
    reset = 1'b0;

    // Clean press, glitch rejection, re-press, simultaneous release/press (TICK_DIV=1, ST=4)
    add(4'b0001, 4'b0000, 4'b0000, 1);
    add(4'b0001, 4'b0000, 4'b0001, 4);
    add(4'b0001, 4'b0001, 4'b0000, 1);
    add(4'b0011, 4'b0001, 4'b0000, 1);
    add(4'b0011, 4'b0001, 4'b0010, 2);
    add(4'b0001, 4'b0001, 4'b0010, 1);
    add(4'b0001, 4'b0001, 4'b0000, 2);
    add(4'b0011, 4'b0001, 4'b0000, 1);
    add(4'b0011, 4'b0001, 4'b0010, 4);
    add(4'b0011, 4'b0011, 4'b0000, 2);
    add(4'b1010, 4'b0011, 4'b0000, 1);
    add(4'b1010, 4'b0011, 4'b1001, 4);
    add(4'b1010, 4'b1010, 4'b0000, 2);
    apply_a("tbl");

    // Async reset mid-window: channel 2 has counted one tick when reset lands between edges
    raw_a = 4'b1110;
    @(posedge clock);
    @(negedge clock);
    @(posedge clock);
    #1;
    check("pre_rst_sett", 32'(sett_a), 32'(4'b0100));
    @(negedge clock);
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_dout", 32'(dout_a), 0);
    check("async_rst_sett", 32'(sett_a), 0);
    raw_a = 4'b1111;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    add(4'b1111, 4'b0000, 4'b0000, 1);
    add(4'b1111, 4'b0000, 4'b1111, 4);
    add(4'b1111, 4'b1111, 4'b0000, 2);
    apply_a("post_rst");

    // Tick cadence, TICK_DIV=5
    do_reset();
    check("tick_at_release", 32'(dut_c.u_tick.tick), 0);
    tick_hits = 0;
    for (int n = 1; n <= 50; n++) begin
      @(posedge clock);
      #1;
      check($sformatf("tick_after_edge%0d", n), 32'(dut_c.u_tick.tick), 32'((n % 5) == 4));
      if (dut_c.u_tick.tick) tick_hits++;
    end
    check("tick_count_50", 32'(tick_hits), 10);

    // Bounce then settle on dut_b channel 2 (TICK_DIV=3, ST=2)
    do_reset();
    rise_edge = -1;
    trans     = 0;
    prev      = 1'b0;
    for (int e = 0; e < 20; e++) begin
      raw_b    = 4'b0000;
      raw_b[2] = (e < 5) ? ((e % 2) == 0) : 1'b1;
      @(posedge clock);
      #1;
      if (dout_b[2] != prev) trans++;
      if (dout_b[2] && rise_edge < 0) rise_edge = e;
      prev = dout_b[2];
      @(negedge clock);
    end
    settle_edge = 5;
    exp_rise    = settle_edge + 1;
    while ((exp_rise % TD_B) != TD_B - 1) exp_rise++;
    exp_rise += TD_B * (ST_B - 1);
    check("bounce_rise_edge", 32'(rise_edge), 32'(exp_rise));
    check("bounce_rise_window", 32'((rise_edge - settle_edge >= (ST_B - 1) * TD_B + 1) &&
                                    (rise_edge - settle_edge <= ST_B * TD_B)), 1);
    check("bounce_transitions", 32'(trans), 1);
    check("bounce_final_dout", 32'(dout_b), 32'(4'b0100));
    check("bounce_final_sett", 32'(sett_b), 0);

    // Randomized stimulus on dut_c against the model
    do_reset();
    m_s1 = '0; m_s2 = '0; m_dout = '0; tph = 0;
    for (int i = 0; i < 4; i++) win_ticks[i] = 0;
    raw_c = 4'($urandom_range(0, 15));
    model_step();
    for (int c = 0; c < 2000; c++) begin
      @(negedge clock);
      check($sformatf("rnd_dout_c%0d", c), 32'(dout_c), 32'(m_dout));
      check($sformatf("rnd_sett_c%0d", c), 32'(sett_c), 32'(m_s2 ^ m_dout));
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 15) == 0) raw_c[i] = ~raw_c[i];
      model_step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
